// File: rtl/color_history_mem_ctrl_pkg.sv
// Shared constants, types and address helpers for the colour-history
// SRAM controller (640x480 pixels, 4 history bits per pixel).
package color_hist_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int ADDR_W   = 19;
  localparam int HIST_W   = 4;

  // One queued write-back: target address and history value.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [HIST_W-1:0] data;
  } wb_entry_t;

  // Operation placed on the SRAM port in a given cycle.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } sram_op_e;

  // Side information travelling alongside a read until its data returns.
  typedef struct packed {
    logic              valid;
    logic              in_range;
    logic              fwd_hit;
    logic [HIST_W-1:0] fwd_data;
    logic [ADDR_W-1:0] addr;
    logic [9:0]        x;
    logic [9:0]        y;
  } ret_meta_t;

  // Linear address y*640 + x built from shifts, kept at 19 bits.
  function automatic logic [ADDR_W-1:0] calc_addr(input logic [9:0] x,
                                                  input logic [9:0] y);
    logic [ADDR_W-1:0] yw;
    logic [ADDR_W-1:0] xw;
    yw = {9'd0, y};
    xw = {9'd0, x};
    return (yw << 9) + (yw << 7) + xw;
  endfunction

  function automatic logic in_screen(input logic [9:0] x, input logic [9:0] y);
    return (x < 10'(SCREEN_W)) && (y < 10'(SCREEN_H));
  endfunction

endpackage

// File: rtl/color_history_mem_ctrl_if.sv
// Bus bundle for color_history_mem_ctrl: pixel requests, returned history,
// detector write-backs, SRAM port and status.
//
// Handshake semantics: there is no ready anywhere. pix_valid and wb_we are
// single-cycle strobes that the controller always accepts in the cycle they
// are high (write-backs may be dropped and counted when the FIFO is full).
// color_valid is a single-cycle strobe qualifying color_history and read_*.
// sram_ce marks an SRAM operation in that cycle; sram_we selects write.
interface color_history_mem_ctrl_if #(
  parameter int CNT_W = 16
);
  import color_hist_pkg::*;

  logic              pix_valid;
  logic [9:0]        pix_x;
  logic [9:0]        pix_y;

  logic [HIST_W-1:0] color_history;
  logic              color_valid;
  logic [ADDR_W-1:0] read_addr;
  logic [9:0]        read_x;
  logic [9:0]        read_y;

  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [HIST_W-1:0] wb_data;

  logic              sram_ce;
  logic              sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [HIST_W-1:0] sram_wdata;
  logic [HIST_W-1:0] sram_rdata;

  logic [CNT_W-1:0]  wb_overflow;
  logic              rate_err;

  // Controller side.
  modport slave (
    input  pix_valid, pix_x, pix_y, wb_we, wb_addr, wb_data, sram_rdata,
    output color_history, color_valid, read_addr, read_x, read_y,
           sram_ce, sram_we, sram_addr, sram_wdata, wb_overflow, rate_err
  );

  // Environment side (pixel source, detector, SRAM).
  modport master (
    output pix_valid, pix_x, pix_y, wb_we, wb_addr, wb_data, sram_rdata,
    input  color_history, color_valid, read_addr, read_x, read_y,
           sram_ce, sram_we, sram_addr, sram_wdata, wb_overflow, rate_err
  );

endinterface

// File: rtl/color_history_mem_ctrl_wb_fifo.sv
// chm_wb_fifo: write-back FIFO built as a shift register so that entry 0 is
// always the oldest. That keeps the forwarding search trivially ordered.
module chm_wb_fifo
  import color_hist_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  wb_entry_t                  push_data_i,
  input  logic                       pop_i,
  output wb_entry_t                  head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output wb_entry_t                  entries_o [DEPTH],
  output logic [DEPTH-1:0]           valid_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_entry_t       mem_q [DEPTH];
  wb_entry_t       mem_d [DEPTH];
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   slot;
  logic            do_pop, do_push;

  // Next contents: shift on pop, then place a push behind the last survivor.
  always_comb begin
    mem_d   = mem_q;
    do_pop  = pop_i && (cnt_q != '0);
    do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);
    slot    = do_pop ? (cnt_q - CW'(1)) : cnt_q;
    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
      mem_d[DEPTH-1] = '0;
    end
    if (do_push) mem_d[slot[AW-1:0]] = push_data_i;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

  // Occupancy mask: entries below the count hold live data.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) valid_o[i] = (CW'(i) < cnt_q);
  end

  assign head_o    = mem_q[0];
  assign entries_o = mem_q;
  assign count_o   = cnt_q;
  assign full_o    = (cnt_q == CW'(DEPTH));
  assign empty_o   = (cnt_q == '0);

endmodule

// File: rtl/color_history_mem_ctrl.sv
// color_history_mem_ctrl: owns the single-port colour-history SRAM. Pixel
// reads always win the port; queued write-backs drain in read-free cycles.
// Read side information rides a matched-delay pipeline to the data return.
// Optional macro CHM_RAW_FWD_EN: return queued write-back data for reads that
// hit a pending write instead of the (stale) SRAM contents.
module color_history_mem_ctrl
  import color_hist_pkg::*;
#(
  parameter int SRAM_LAT = 2,
  parameter int WB_DEPTH = 8,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  color_history_mem_ctrl_if.slave  bus
);
  localparam int CW = $clog2(WB_DEPTH) + 1;

  logic [ADDR_W-1:0] pix_addr;
  logic              pix_in_range, rd_req, pop, drop, push_ok;
  wb_entry_t         head, push_entry;
  wb_entry_t         entries [WB_DEPTH];
  logic [WB_DEPTH-1:0] ent_valid;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              fwd_hit;
  logic [HIST_W-1:0] fwd_data;

  sram_op_e          op_q, op_d;
  logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [HIST_W-1:0] sram_wdata_q, sram_wdata_d;
  ret_meta_t         pipe_q [SRAM_LAT+1];
  ret_meta_t         meta_d;
  logic [CNT_W-1:0]  ovf_q;
  logic              pv_prev_q, rate_q;
  logic [HIST_W-1:0] hist;

  assign pix_addr     = calc_addr(bus.pix_x, bus.pix_y);
  assign pix_in_range = in_screen(bus.pix_x, bus.pix_y);
  assign rd_req       = bus.pix_valid && pix_in_range;
  assign pop          = !rd_req && !fifo_empty;
  assign drop         = bus.wb_we && fifo_full && !pop;
  assign push_ok      = bus.wb_we && !drop;
  assign push_entry   = '{addr: bus.wb_addr, data: bus.wb_data};

  chm_wb_fifo #(.DEPTH(WB_DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .push_i      (bus.wb_we),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count),
    .entries_o   (entries),
    .valid_o     (ent_valid)
  );

`ifdef CHM_RAW_FWD_EN
  // Newest matching pending write wins; an accepted same-cycle push is newest.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (ent_valid[i] && (entries[i].addr == pix_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[i].data;
      end
    end
    if (push_ok && (bus.wb_addr == pix_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = bus.wb_data;
    end
  end
  logic unused_fwd;
  assign unused_fwd = ^fifo_count;
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
  logic unused_fwd;
  assign unused_fwd = ^{fifo_count, ent_valid, push_ok, entries[0]};
`endif

  // Arbitration: a pixel read takes the port, else the FIFO head is written.
  always_comb begin
    op_d         = OP_IDLE;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    if (rd_req) begin
      op_d        = OP_READ;
      sram_addr_d = pix_addr;
    end else if (pop) begin
      op_d         = OP_WRITE;
      sram_addr_d  = head.addr;
      sram_wdata_d = head.data;
    end
  end

  // SRAM port registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q         <= OP_IDLE;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
    end else begin
      op_q         <= op_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
    end
  end

  // Side information captured in the pixel cycle.
  always_comb begin
    meta_d          = '0;
    meta_d.valid    = bus.pix_valid;
    meta_d.in_range = pix_in_range;
    meta_d.fwd_hit  = fwd_hit;
    meta_d.fwd_data = fwd_data;
    meta_d.addr     = pix_addr;
    meta_d.x        = bus.pix_x;
    meta_d.y        = bus.pix_y;
  end

  // Matched-delay return pipeline; last stage lines up with sram_rdata.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i <= SRAM_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= meta_d;
      for (int i = 1; i <= SRAM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Overflow counter (saturating) and sticky back-to-back pixel flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q     <= '0;
      pv_prev_q <= 1'b0;
      rate_q    <= 1'b0;
    end else begin
      if (drop && (ovf_q != {CNT_W{1'b1}})) ovf_q <= ovf_q + CNT_W'(1);
      pv_prev_q <= bus.pix_valid;
      rate_q    <= rate_q | (bus.pix_valid & pv_prev_q);
    end
  end

  // Returned history: zero outside a return strobe or for off-screen pixels.
  always_comb begin
    hist = '0;
    if (pipe_q[SRAM_LAT].valid && pipe_q[SRAM_LAT].in_range)
      hist = pipe_q[SRAM_LAT].fwd_hit ? pipe_q[SRAM_LAT].fwd_data : bus.sram_rdata;
  end

  assign bus.color_history = hist;
  assign bus.color_valid   = pipe_q[SRAM_LAT].valid;
  assign bus.read_addr     = pipe_q[SRAM_LAT].addr;
  assign bus.read_x        = pipe_q[SRAM_LAT].x;
  assign bus.read_y        = pipe_q[SRAM_LAT].y;
  assign bus.sram_ce       = (op_q != OP_IDLE);
  assign bus.sram_we       = (op_q == OP_WRITE);
  assign bus.sram_addr     = sram_addr_q;
  assign bus.sram_wdata    = sram_wdata_q;
  assign bus.wb_overflow   = ovf_q;
  assign bus.rate_err      = rate_q;

endmodule
